// File: rtl/debounce_pkg.sv
// Shared constants for the input debouncer.
package debounce_pkg;

    localparam int unsigned SYS_CLK_HZ        = 100_000_000;
    // 10 ms of stability at SYS_CLK_HZ.
    localparam int unsigned DEBOUNCE_10MS     = 1_000_000;
    // Short filter length used in simulation.
    localparam int unsigned SIM_STABLE_CYCLES = 4;

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter and registered edge pulses.
module debounce_channel #(
    parameter int unsigned STABLE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Filter next state: count consecutive disagreeing cycles, accept on the last one.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = s2_q;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser and filter state, synchronous reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw_in;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db_level = level_q;
    assign db_rise  = rise_q;
    assign db_fall  = fall_q;

endmodule : debounce_channel

// File: rtl/input_debouncer.sv
// Debounces WIDTH independent pad inputs; one debounce_channel per bit.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_10MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_level,
    output logic [WIDTH-1:0] db_rise,
    output logic [WIDTH-1:0] db_fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .raw_in  (raw_in[i]),
            .db_level(db_level[i]),
            .db_rise (db_rise[i]),
            .db_fall (db_fall[i])
        );
    end

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus random stimulus, scoreboard-checked.
module tb_input_debouncer;
    import debounce_pkg::*;

    localparam int unsigned W  = 2;
    localparam int unsigned SC = SIM_STABLE_CYCLES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] db_level, db_rise, db_fall;

    int errors = 0;
    int checks = 0;

    input_debouncer #(
        .WIDTH        (W),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .raw_in  (raw_in),
        .db_level(db_level),
        .db_rise (db_rise),
        .db_fall (db_fall)
    );

    always #5 clk = ~clk;

    // Expected {level, rise, fall} after each edge.
    logic [3*W-1:0] exp_q[$];

    // Reference model: the input reaches the filter two edges late; a channel
    // accepts when its last SC delayed samples since the previous acceptance
    // all disagree with the current level.
    logic [W-1:0] m_level = '0;
    logic [W-1:0] m_d1 = '0, m_d2 = '0;
    bit           win[W][$];

    always @(posedge clk) begin
        logic [W-1:0] r, f;
        bit           ok;
        r = '0;
        f = '0;
        if (rst) begin
            m_level = '0;
            m_d1    = '0;
            m_d2    = '0;
            for (int c = 0; c < W; c++) win[c].delete();
        end else begin
            for (int c = 0; c < W; c++) begin
                win[c].push_back(m_d2[c]);
                if (win[c].size() > SC) void'(win[c].pop_front());
                ok = (win[c].size() == SC);
                foreach (win[c][k]) if (win[c][k] == m_level[c]) ok = 1'b0;
                if (ok) begin
                    m_level[c] = ~m_level[c];
                    r[c]       = m_level[c];
                    f[c]       = ~m_level[c];
                    win[c].delete();
                end
            end
            m_d2 = m_d1;
            m_d1 = raw_in;
        end
        exp_q.push_back({m_level, r, f});
    end

    // Monitor: compare DUT outputs at mid-cycle against the scoreboard.
    always @(negedge clk) begin
        logic [3*W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 3;
            if (db_level !== e[3*W-1:2*W]) begin
                errors++;
                $display("FAIL level t=%0t got=%b exp=%b", $time, db_level, e[3*W-1:2*W]);
            end
            if (db_rise !== e[2*W-1:W]) begin
                errors++;
                $display("FAIL rise t=%0t got=%b exp=%b", $time, db_rise, e[2*W-1:W]);
            end
            if (db_fall !== e[W-1:0]) begin
                errors++;
                $display("FAIL fall t=%0t got=%b exp=%b", $time, db_fall, e[W-1:0]);
            end
        end
    end

    task automatic drive(input logic [W-1:0] v, input int n);
        raw_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] bounce;
        bounce = 9'b111101101;  // applied LSB first: 1,0,1,1,0,1,1,1,1

        // Input high through reset.
        rst = 1'b1;
        drive(2'b11, 3);
        rst = 1'b0;
        drive(2'b11, 10);
        // Clean steps on bit 0.
        drive(2'b00, 10);
        drive(2'b01, 10);
        drive(2'b00, 10);
        // Bounce on bit 1.
        for (int i = 0; i < 9; i++) drive({bounce[i], 1'b0}, 1);
        drive(2'b10, 8);
        drive(2'b00, 10);
        // Single-cycle glitch.
        drive(2'b01, 1);
        drive(2'b00, 10);
        // Simultaneous step.
        drive(2'b11, 10);
        drive(2'b00, 10);
        // Reset mid-count.
        drive(2'b01, 2);
        rst = 1'b1;
        drive(2'b01, 2);
        rst = 1'b0;
        drive(2'b01, 10);
        drive(2'b00, 10);
        // Random phases with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                drive(W'($urandom_range(0, 3)), $urandom_range(1, 2));
                rst = 1'b0;
            end
            drive(W'($urandom_range(0, 3)), $urandom_range(1, 8));
        end
        drive(raw_in, 2);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_input_debouncer
